// File: rtl/onn_phase_loader.sv
// onn_phase_loader
//   Serial-to-parallel phase/weight loader for the ONN neuron array. A framed,
//   MSB-first serial stream is assembled into ROWS x COLS words of WBITS bits.
//   The completed frame is published on phi_out_o with a valid/ready handshake.
//   phi_out_o only ever changes when a whole frame completes.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   start_i      frame-sync pulse; opens (or restarts) a frame
//   bit_in_i     serial data bit
//   bit_valid_i  bit_in_i qualifier
//   phi_ready_i  consumer accepts the frame on phi_out_o
//   phi_out_o    assembled frame, word k at [k*WBITS +: WBITS], MSB at low index
//   phi_valid_o  phi_out_o holds a new, unconsumed frame
//   busy_o       high while shifting or holding a frame
//   row_idx_o    row of the word the next accepted bit fills
//   col_idx_o    column of the word the next accepted bit fills
//   err_o        one-cycle parity-error pulse
//
// Configuration
//   ONN_LOADER_PARITY_EN : when defined, one even-parity bit follows the N data
//   bits. A mismatch pulses err_o and drops the frame. When undefined, err_o
//   is tied to 0 and a frame is exactly N bits.

module onn_phase_loader #(
  parameter int ROWS  = 5,
  parameter int COLS  = 3,
  parameter int WBITS = 4,
  localparam int N    = ROWS * COLS * WBITS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         bit_in_i,
  input  logic         bit_valid_i,
  input  logic         phi_ready_i,
  output logic [0:N-1] phi_out_o,
  output logic         phi_valid_o,
  output logic         busy_o,
  output logic [2:0]   row_idx_o,
  output logic [1:0]   col_idx_o,
  output logic         err_o
);

  localparam int BW = (WBITS > 1) ? $clog2(WBITS) : 1;
  localparam int NW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t         state_q, state_d;
  logic [0:N-1]   shift_q, shift_d;
  logic [0:N-1]   phi_q, phi_d;
  logic           vld_q, vld_d;
  logic [NW-1:0]  n_q, n_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [1:0]     col_q, col_d;
  logic [2:0]     row_q, row_d;
  logic           adv, clr;
`ifdef ONN_LOADER_PARITY_EN
  logic           par_q, par_d;
  logic           err_q, err_d;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    phi_d   = phi_q;
    vld_d   = vld_q;
    adv     = 1'b0;
    clr     = 1'b0;
`ifdef ONN_LOADER_PARITY_EN
    par_d   = par_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // bit_in is ignored in the start cycle: the first data bit follows it
        if (start_i) begin
          state_d = SHIFT;
          clr     = 1'b1;
        end
      end
      SHIFT: begin
        if (start_i) begin
          // restart; the partial frame is overwritten before it can complete
          clr = 1'b1;
        end else if (bit_valid_i) begin
`ifdef ONN_LOADER_PARITY_EN
          if (n_q == NW'(N)) begin
            clr = 1'b1;
            if (par_q ^ bit_in_i) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              phi_d   = shift_q;
              vld_d   = 1'b1;
              state_d = HOLD;
            end
          end else begin
            shift_d[n_q] = bit_in_i;
            par_d        = par_q ^ bit_in_i;
            adv          = 1'b1;
          end
`else
          shift_d[n_q] = bit_in_i;
          adv          = 1'b1;
          if (n_q == NW'(N - 1)) begin
            phi_d   = shift_d;
            vld_d   = 1'b1;
            state_d = HOLD;
            clr     = 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        // stream input is dropped here; only the consumer can release us
        if (phi_ready_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    n_d   = n_q;
    bit_d = bit_q;
    col_d = col_q;
    row_d = row_q;
    if (adv) begin
      n_d = n_q + NW'(1);
      if (bit_q == BW'(WBITS - 1)) begin
        bit_d = '0;
        if (col_q == 2'(COLS - 1)) begin
          col_d = '0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 2'd1;
        end
      end else begin
        bit_d = bit_q + BW'(1);
      end
    end
    if (clr) begin
      n_d   = '0;
      bit_d = '0;
      col_d = '0;
      row_d = '0;
`ifdef ONN_LOADER_PARITY_EN
      par_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      phi_q   <= '0;
      vld_q   <= 1'b0;
      n_q     <= '0;
      bit_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
`ifdef ONN_LOADER_PARITY_EN
      par_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      phi_q   <= phi_d;
      vld_q   <= vld_d;
      n_q     <= n_d;
      bit_q   <= bit_d;
      col_q   <= col_d;
      row_q   <= row_d;
`ifdef ONN_LOADER_PARITY_EN
      par_q   <= par_d;
      err_q   <= err_d;
`endif
    end
  end

  assign phi_out_o   = phi_q;
  assign phi_valid_o = vld_q;
  assign busy_o      = (state_q != IDLE);
  assign row_idx_o   = row_q;
  assign col_idx_o   = col_q;
`ifdef ONN_LOADER_PARITY_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_onn_phase_loader.sv
// Directed bench for onn_phase_loader: a frame-level model (bit list, count,
// hold flag) is checked against the DUT every negedge, plus hand-computed
// literal checks at the interesting points of each scenario.

module tb_onn_phase_loader;
  localparam int ROWS = 5, COLS = 3, WBITS = 4, N = 60;
`ifdef ONN_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = N + PAR;
  localparam logic [0:N-1] NOM  = 60'hFFF00FFFFF00FFF;
  localparam logic [0:N-1] ONES = {N{1'b1}};

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, phi_ready = 1'b0;
  logic [0:N-1] phi_out;
  logic phi_valid, busy, err;
  logic [2:0] row_idx;
  logic [1:0] col_idx;

  int nvec = 0, nerr = 0;
  bit chk_on = 1'b0;

  onn_phase_loader #(.ROWS(ROWS), .COLS(COLS), .WBITS(WBITS)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bit_in_i(bit_in),
    .bit_valid_i(bit_valid), .phi_ready_i(phi_ready), .phi_out_o(phi_out),
    .phi_valid_o(phi_valid), .busy_o(busy), .row_idx_o(row_idx),
    .col_idx_o(col_idx), .err_o(err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int           m_cnt = 0, ones;
  bit           m_active = 0, m_hold = 0, m_valid = 0, m_err = 0;
  logic [0:N-1] m_phi = '0;
  bit           m_bits [0:N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_active = 0; m_hold = 0; m_valid = 0; m_err = 0; m_phi = '0;
    end else begin
      m_err = 0;
      if (m_hold) begin
        if (phi_ready) begin m_hold = 0; m_valid = 0; end
      end else if (start) begin
        m_active = 1; m_cnt = 0;
      end else if (m_active && bit_valid) begin
        m_bits[m_cnt] = bit_in;
        m_cnt++;
        if (m_cnt == L) begin
          ones = 0;
          for (int i = 0; i < L; i++) ones += int'(m_bits[i]);
          m_active = 0; m_cnt = 0;
          if (PAR == 0 || ones % 2 == 0) begin
            for (int i = 0; i < N; i++) m_phi[i] = m_bits[i];
            m_valid = 1; m_hold = 1;
          end else m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("phi_out",   64'(phi_out),   64'(m_phi));
      chk("phi_valid", 64'(phi_valid), 64'(m_valid));
      chk("busy",      64'(busy),      64'(m_active || m_hold));
      chk("row_idx",   64'(row_idx),   64'(m_cnt / (COLS * WBITS)));
      chk("col_idx",   64'(col_idx),   64'((m_cnt / WBITS) % COLS));
      chk("err",       64'(err),       64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic nom(input int n);
    return (n < 12) || (n >= 20 && n < 40) || (n >= 48);
  endfunction

  // called at posedge+1; inputs are sampled on the next posedge
  task automatic cyc(input logic s, input logic b, input logic v, input logic r);
    start = s; bit_in = b; bit_valid = v; phi_ready = r;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, k;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_phi_out", 64'(phi_out), 64'd0);
    chk("rst_valid", 64'(phi_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_idx", 64'({row_idx, col_idx}), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_on = 1'b1;

    // nominal frame; a valid bit during the start cycle must be ignored
    cyc(1, 0, 1, 0);
    for (int i = 0; i < N; i++) cyc(0, nom(i), 1, 0);
    if (PAR != 0) cyc(0, 0, 1, 0);
    chk("nom_phi_out", 64'(phi_out), 64'(NOM));
    chk("nom_valid", 64'(phi_valid), 64'd1);
    chk("nom_idx_zero", 64'({row_idx, col_idx}), 64'd0);

    // hold protection
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    chk("hold_phi_out", 64'(phi_out), 64'(NOM));
    chk("hold_valid", 64'(phi_valid), 64'd1);
    cyc(0, 0, 0, 1);
    chk("ack_valid", 64'(phi_valid), 64'd0);
    chk("ack_busy", 64'(busy), 64'd0);
    cyc(0, 0, 0, 1);  // ready with nothing held

    // gapped stream: bit_valid low every third cycle, junk on bit_in
    cyc(1, 0, 0, 0);
    n = 0; k = 0;
    while (n < L) begin
      if (k % 3 == 2) cyc(0, 1'($urandom_range(1)), 0, 0);
      else begin
        cyc(0, (n < N) ? nom(n) : 1'b0, 1, 0);
        n++;
      end
      k++;
    end
    chk("gap_phi_out", 64'(phi_out), 64'(NOM));
    cyc(0, 0, 0, 1);

    // restart after 23 bits
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 23; i++) cyc(0, nom(i), 1, 0);
    chk("part_row", 64'(row_idx), 64'd1);
    chk("part_col", 64'(col_idx), 64'd2);
    chk("part_phi_out", 64'(phi_out), 64'(NOM));
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 1, 1, 0);
    if (PAR != 0) cyc(0, 0, 1, 0);
    chk("rst_frame_ones", 64'(phi_out), 64'(ONES));
    cyc(0, 0, 0, 1);

`ifdef ONN_LOADER_PARITY_EN
    // load NOM back so retention after a bad frame is visible
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, nom(i), 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk("par_err", 64'(err), 64'd1);
    chk("par_valid", 64'(phi_valid), 64'd0);
    chk("par_keep", 64'(phi_out), 64'(NOM));
    cyc(0, 0, 0, 0);
    chk("par_err_pulse", 64'(err), 64'd0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    chk("par_ok_valid", 64'(phi_valid), 64'd1);
    chk("par_ok_phi", 64'(phi_out), 64'(ONES));
    cyc(0, 0, 0, 1);
`endif

    // asynchronous reset mid-shift
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_phi_out", 64'(phi_out), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(phi_valid), 64'd0);
    chk("arst_idx", 64'({row_idx, col_idx}), 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    cyc(0, 1, 1, 0);  // bits without start are ignored in IDLE
    chk("arst_idle", 64'(busy), 64'd0);

    repeat (3) cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
